// File: rtl/mul_exec_unit.sv
// Iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Uses a radix-2 shift-add over unsigned magnitudes. The sign is applied once, on the
// edge that enters DONE. Exposes the mul_state/mul_done/rd_mul_update handshake to the
// scoreboard and holds the result until writeback acknowledges it.
module mul_exec_unit #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mul_load,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [1:0]      op_sel,
   input  logic [RD_W-1:0] rd_in,
   input  logic            wb_ack,
   input  logic            flush,
   output logic [1:0]      mul_state,
   output logic            mul_done,
   output logic [RD_W-1:0] rd_mul_update,
   output logic [XLEN-1:0] mul_result
);

   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [1:0] SEL_MUL   = 2'b00;
   localparam logic [1:0] SEL_MULH  = 2'b01;
   localparam logic [1:0] SEL_MULHU = 2'b11;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_mcand;    // |op_a|, shifted left one place per cycle
   logic [XLEN-1:0]   r_mplier;   // |op_b|, consumed LSB first
   logic [2*XLEN-1:0] r_acc;
   logic              r_neg;
   logic [1:0]        r_sel;
   logic [RD_W-1:0]   r_rd;
   logic              r_done;
   logic [RD_W-1:0]   r_rd_out;
   logic [XLEN-1:0]   r_result;

   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;
   logic [2*XLEN-1:0] w_sum;
   logic [2*XLEN-1:0] w_prod;
   logic              w_last;

   // Operand magnitudes, the partial-product add and the signed final product.
   always_comb begin
      // op_a is signed for every op except MULHU; op_b is signed only for MUL and MULH.
      w_a_neg = (op_sel != SEL_MULHU) && op_a[XLEN-1];
      w_b_neg = ((op_sel == SEL_MUL) || (op_sel == SEL_MULH)) && op_b[XLEN-1];
      // The magnitude of the most-negative value is 2^(XLEN-1) and still fits unsigned.
      w_abs_a = w_a_neg ? XLEN'(-op_a) : op_a;
      w_abs_b = w_b_neg ? XLEN'(-op_b) : op_b;
      w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_prod  = r_neg ? (2*XLEN)'(-w_sum) : w_sum;
      w_last  = (r_cnt == CNT_W'(XLEN - 1));
   end

   // Control FSM and multiply datapath. Flush overrides every state.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments everywhere here. Every register samples its
      // pre-edge value, so the order of the statements does not matter.
      if (!rst_n) begin
         // NOTE: the datapath registers are reset along with the control state. This keeps
         // the outputs deterministic, and none of these registers are memories.
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_sel    <= '0;
         r_rd     <= '0;
         r_done   <= 1'b0;
         r_rd_out <= '0;
         r_result <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mul_load) begin
                  r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
                  r_mplier <= w_abs_b;
                  r_acc    <= '0;
                  r_neg    <= w_a_neg ^ w_b_neg;
                  r_sel    <= op_sel;
                  r_rd     <= rd_in;
                  r_cnt    <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_rd_out <= r_rd;
                  r_result <= (r_sel == SEL_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
               end
            end
            S_DONE: begin
               if (wb_ack) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               // An upset into state 2'b11 returns to IDLE with the outputs cleared.
               r_state  <= S_IDLE;
               r_done   <= 1'b0;
               r_rd_out <= '0;
               r_result <= '0;
            end
         endcase
      end
   end

   assign mul_state     = r_state;
   assign mul_done      = r_done;
   assign rd_mul_update = r_rd_out;
   assign mul_result    = r_result;

endmodule
